// File: rtl/proj_pkg.sv
// Project-wide word definitions shared by the datapath and its result buffer.
package proj_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/result_fifo_mem.sv
// Storage array for result_fifo: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module result_fifo_mem
    import proj_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = WORD_W
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/result_fifo.sv
// Show-ahead result buffer between the datapath done strobe and a valid/ready
// consumer. Optional drop counter enabled by RESULT_FIFO_DROP_CNT_EN.
module result_fifo
    import proj_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = WORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         result,
    input  logic                     done,
    input  logic                     clr_ovf,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
`ifdef RESULT_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, drop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign pop  = out_valid && out_ready;
    assign push = done && (!full || pop);
    assign drop = done && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef RESULT_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] drop_base;

    // A drop in the clearing cycle is still counted after the clear.
    always_comb begin
        drop_base  = clr_ovf ? 16'd0 : drop_cnt_q;
        drop_cnt_d = drop_base;
        if (drop && (drop_base != 16'hFFFF)) begin
            drop_cnt_d = drop_base + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    result_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (result),
        .rd_addr (rd_ptr_q),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_result_fifo.sv
// Scoreboard bench for result_fifo; covers the drop counter when
// RESULT_FIFO_DROP_CNT_EN is defined.
module tb_result_fifo;
    import proj_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    word_t       result;
    logic        done;
    logic        clr_ovf;
    word_t       out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
`ifdef RESULT_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int    checks   = 0;
    int    failures = 0;
    word_t sb[$];
    logic  ovf_m;
    int    drops_m;
    word_t last_pop;

    always #5 clk = ~clk;

    result_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .result    (result),
        .done      (done),
        .clr_ovf   (clr_ovf),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
`ifdef RESULT_FIFO_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check state against the model before the
    // edge, then update the model with what the edge should do.
    task automatic cycle(input logic d, input word_t r, input logic rdy, input logic clr);
        int    sz;
        logic  pop_m, drop_m;
        word_t exp;
        done      = d;
        result    = r;
        out_ready = rdy;
        clr_ovf   = clr;
        @(negedge clk);
        sz = sb.size();
        chk("count", 32'(count), 32'(sz));
        chk("out_valid", 32'(out_valid), 32'(sz != 0));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        pop_m  = rdy && (sz != 0);
        drop_m = d && (sz == DEPTH) && !pop_m;
        if (pop_m) begin
            exp      = sb.pop_front();
            last_pop = out_data;
            chk("out_data", out_data, exp);
        end
        if (d && !drop_m) sb.push_back(r);
        if (drop_m) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        if (clr) drops_m = 0;
        if (drop_m && drops_m < 16'hFFFF) drops_m++;
        @(posedge clk);
        #1;
        done    = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic fill(input word_t base);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, base + word_t'(i), 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; done = 1'b0; result = '0; clr_ovf = 1'b0; out_ready = 1'b0;
        ovf_m = 1'b0; drops_m = 0; last_pop = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        // basic order and show-ahead
        cycle(1'b1, 32'd5, 1'b0, 1'b0);
        cycle(1'b1, 32'd9, 1'b0, 1'b0);
        cycle(1'b1, 32'd13, 1'b0, 1'b0);
        chk("three_count", 32'(count), 32'd3);
        chk("three_head", out_data, 32'd5);
        drain();
        chk("three_last", last_pop, 32'd13);

        // overflow: 99 dropped
        fill(32'd1);
        cycle(1'b1, 32'd99, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        drain();
        chk("ovf_last", last_pop, 32'd8);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // push and pop together while full
        fill(32'd21);
        cycle(1'b1, 32'd77, 1'b1, 1'b0);
        chk("full_pp_count", 32'(count), 32'd8);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        drain();
        chk("full_pp_last", last_pop, 32'd77);

        // sustained streaming, pointers wrap
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'd100 + 32'(i), 1'b1, 1'b0);
        chk("stream_ovf", 32'(overflow), 32'd0);
        drain();
        chk("stream_last", last_pop, 32'd119);

        // asynchronous reset with words queued
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'd200 + 32'(i), 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        sb.delete();
        ovf_m = 1'b0;
        drops_m = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'd42, 1'b0, 1'b0);
        chk("arst_head", out_data, 32'd42);
        drain();
        chk("arst_first", last_pop, 32'd42);

`ifdef RESULT_FIFO_DROP_CNT_EN
        fill(32'd300);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'd400, 1'b0, 1'b0);
        chk("drop_cnt3", 32'(drop_cnt), 32'(drops_m));
        chk("drop_cnt3_abs", 32'(drop_cnt), 32'd3);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("drop_cnt_clr", 32'(drop_cnt), 32'd0);
        chk("drop_ovf_clr", 32'(overflow), 32'd0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
